// File: rtl/poc_pkg.sv
// rtl/poc_pkg.sv - shared codes and widths for the poc datapath
// Writeback destinations reuse the A-mux source-select encoding where they overlap.
package poc_pkg;

  localparam int POC_DATA_W = 18;
  localparam int POC_IDR_W  = 9;
  localparam int POC_DEST_W = 3;

  typedef enum logic [POC_DEST_W-1:0] {
    DEST_NONE    = 3'd0,
    DEST_IDR     = 3'd1,
    DEST_MDR     = 3'd2,
    DEST_RCOL    = 3'd3,
    DEST_RROW    = 3'd4,
    DEST_AC      = 3'd5,
    DEST_R1      = 3'd6,
    DEST_ILLEGAL = 3'd7
  } poc_dest_e;

  typedef enum logic [POC_DEST_W-1:0] {
    ASEL_IDR  = 3'd1,
    ASEL_MDR  = 3'd2,
    ASEL_RCOL = 3'd3,
    ASEL_RROW = 3'd4,
    ASEL_AC   = 3'd5,
    ASEL_R1   = 3'd6
  } poc_asel_e;

  function automatic logic dest_is_write(input poc_dest_e dest);
    return (dest != DEST_NONE) && (dest != DEST_ILLEGAL);
  endfunction

endpackage

// File: rtl/poc_wb_fifo.sv
// rtl/poc_wb_fifo.sv - small synchronous in-order FIFO with occupancy count
// DEPTH must be a power of two so the pointers wrap naturally.
module poc_wb_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/poc_wb_demux.sv
// rtl/poc_wb_demux.sv - ALU result writeback demux with in-order buffer
// Optional POC_WB_STATS_EN adds saturating write/drop counters.
module poc_wb_demux
  import poc_pkg::*;
#(
  parameter int DATA_W = POC_DATA_W,
  parameter int IDR_W  = POC_IDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mdr_busy,
  output logic [DATA_W-1:0] wb_data,
  output logic [IDR_W-1:0]  idr_din,
  output logic              we_idr,
  output logic              we_mdr,
  output logic              we_rcol,
  output logic              we_rrow,
  output logic              we_ac,
  output logic              we_r1,
`ifdef POC_WB_STATS_EN
  output logic [15:0]       stat_writes,
  output logic [15:0]       stat_drops,
`endif
  output logic              err_dest
);

  localparam int ENTRY_W = DATA_W + POC_DEST_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] head_word;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               head_stall;
  poc_dest_e          head_dest;
  logic [DATA_W-1:0]  head_data;

  assign in_ready = (fifo_count != FULL_CNT);
  assign push     = in_valid && !fifo_full;

  poc_wb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_dest, in_data}),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_dest = poc_dest_e'(head_word[DATA_W +: POC_DEST_W]);
  assign head_data = head_word[DATA_W-1:0];

  // Only an MDR head can wait; everything behind it waits too, keeping order.
  assign head_stall = (head_dest == DEST_MDR) && mdr_busy;
  assign pop        = !fifo_empty && !head_stall;

  assign idr_din = wb_data[IDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data  <= '0;
      we_idr   <= 1'b0;
      we_mdr   <= 1'b0;
      we_rcol  <= 1'b0;
      we_rrow  <= 1'b0;
      we_ac    <= 1'b0;
      we_r1    <= 1'b0;
      err_dest <= 1'b0;
    end else begin
      we_idr   <= 1'b0;
      we_mdr   <= 1'b0;
      we_rcol  <= 1'b0;
      we_rrow  <= 1'b0;
      we_ac    <= 1'b0;
      we_r1    <= 1'b0;
      err_dest <= 1'b0;
      if (pop) begin
        case (head_dest)
          DEST_IDR:     we_idr   <= 1'b1;
          DEST_MDR:     we_mdr   <= 1'b1;
          DEST_RCOL:    we_rcol  <= 1'b1;
          DEST_RROW:    we_rrow  <= 1'b1;
          DEST_AC:      we_ac    <= 1'b1;
          DEST_R1:      we_r1    <= 1'b1;
          DEST_ILLEGAL: err_dest <= 1'b1;
          default:      ;
        endcase
        if (dest_is_write(head_dest)) begin
          wb_data <= head_data;
        end
      end
    end
  end

`ifdef POC_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_writes <= '0;
      stat_drops  <= '0;
    end else if (pop) begin
      if (dest_is_write(head_dest)) begin
        if (stat_writes != 16'hFFFF) begin
          stat_writes <= stat_writes + 16'd1;
        end
      end else if (stat_drops != 16'hFFFF) begin
        stat_drops <= stat_drops + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_poc_wb_demux.sv
// tb/tb_poc_wb_demux.sv - directed self-checking bench for poc_wb_demux
// Optional POC_WB_STATS_EN also checks the statistics counters.
module tb_poc_wb_demux;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_dest;
  logic [17:0] in_data;
  logic        mdr_busy;
  logic [17:0] wb_data;
  logic [8:0]  idr_din;
  logic        we_idr, we_mdr, we_rcol, we_rrow, we_ac, we_r1;
  logic        err_dest;
`ifdef POC_WB_STATS_EN
  logic [15:0] stat_writes;
  logic [15:0] stat_drops;
`endif

  int checks = 0;
  int errors = 0;

  poc_wb_demux dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .mdr_busy (mdr_busy),
    .wb_data  (wb_data),
    .idr_din  (idr_din),
    .we_idr   (we_idr),
    .we_mdr   (we_mdr),
    .we_rcol  (we_rcol),
    .we_rrow  (we_rrow),
    .we_ac    (we_ac),
    .we_r1    (we_r1),
`ifdef POC_WB_STATS_EN
    .stat_writes (stat_writes),
    .stat_drops  (stat_drops),
`endif
    .err_dest (err_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {idr, mdr, rcol, rrow, ac, r1}
  logic [5:0] we_vec;
  assign we_vec = {we_idr, we_mdr, we_rcol, we_rrow, we_ac, we_r1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [2:0] dest, input logic [17:0] data);
    in_valid = 1'b1;
    in_dest  = dest;
    in_data  = data;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_dest  = 3'd0;
    in_data  = 18'd0;
    mdr_busy = 1'b0;
    tick();
    tick();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", we_vec, 6'b000000);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_idr_din", idr_din, 0);
    chk("rst_err", err_dest, 0);
    rst = 1'b0;
    tick();

    // single RCOL write
    offer(3'd3, 18'd65);
    tick();
    in_valid = 1'b0;
    chk("t1_no_early_we", we_vec, 6'b000000);
    tick();
    chk("t1_we_rcol", we_vec, 6'b001000);
    chk("t1_wb_data", wb_data, 65);
    tick();
    chk("t1_we_clear", we_vec, 6'b000000);
    chk("t1_wb_hold", wb_data, 65);

    // back-to-back IDR, MDR, RROW
    offer(3'd1, 18'd23);
    tick();
    chk("t2_ready0", in_ready, 1);
    chk("t2_we0", we_vec, 6'b000000);
    offer(3'd2, 18'd19);
    tick();
    chk("t2_we_idr", we_vec, 6'b100000);
    chk("t2_idr_din", idr_din, 23);
    chk("t2_ready1", in_ready, 1);
    offer(3'd4, 18'd54);
    tick();
    in_valid = 1'b0;
    chk("t2_we_mdr", we_vec, 6'b010000);
    chk("t2_wb_mdr", wb_data, 19);
    chk("t2_ready2", in_ready, 1);
    tick();
    chk("t2_we_rrow", we_vec, 6'b000100);
    chk("t2_wb_rrow", wb_data, 54);
    tick();
    chk("t2_we_clear", we_vec, 6'b000000);

    // MDR stall blocks the AC write behind it
    mdr_busy = 1'b1;
    offer(3'd2, 18'd19);
    tick();
    offer(3'd5, 18'd7);
    tick();
    in_valid = 1'b0;
    chk("t3_full", in_ready, 0);
    chk("t3_stall_we0", we_vec, 6'b000000);
    tick();
    tick();
    chk("t3_stall_we1", we_vec, 6'b000000);
    chk("t3_still_full", in_ready, 0);
    mdr_busy = 1'b0;
    tick();
    chk("t3_we_mdr", we_vec, 6'b010000);
    chk("t3_wb_mdr", wb_data, 19);
    chk("t3_ready_back", in_ready, 1);
    tick();
    chk("t3_we_ac", we_vec, 6'b000010);
    chk("t3_wb_ac", wb_data, 7);
    tick();
    chk("t3_we_clear", we_vec, 6'b000000);

    // truncation, discard, illegal
    offer(3'd1, 18'h3FFFF);
    tick();
    offer(3'd0, 18'd5);
    tick();
    chk("t4_we_idr", we_vec, 6'b100000);
    chk("t4_idr_trunc", idr_din, 9'h1FF);
    chk("t4_wb_full", wb_data, 18'h3FFFF);
    offer(3'd7, 18'd9);
    tick();
    in_valid = 1'b0;
    chk("t4_none_we", we_vec, 6'b000000);
    chk("t4_none_err", err_dest, 0);
    chk("t4_none_wb_hold", wb_data, 18'h3FFFF);
    tick();
    chk("t4_ill_err", err_dest, 1);
    chk("t4_ill_we", we_vec, 6'b000000);
    chk("t4_ill_wb_hold", wb_data, 18'h3FFFF);
    tick();
    chk("t4_err_clear", err_dest, 0);
`ifdef POC_WB_STATS_EN
    chk("t4_stat_drops", stat_drops, 2);
    chk("t4_stat_writes", stat_writes, 7);
`endif

    // fill, then reset drops the buffered entries
    mdr_busy = 1'b1;
    offer(3'd2, 18'd1);
    tick();
    offer(3'd3, 18'd2);
    tick();
    chk("t5_full", in_ready, 0);
    offer(3'd1, 18'd99);
    tick();
    in_valid = 1'b0;
    mdr_busy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_we", we_vec, 6'b000000);
    chk("t5_rst_wb", wb_data, 0);
    chk("t5_rst_idr", idr_din, 0);
    chk("t5_rst_err", err_dest, 0);
`ifdef POC_WB_STATS_EN
    chk("t5_rst_writes", stat_writes, 0);
    chk("t5_rst_drops", stat_drops, 0);
`endif
    tick();
    chk("t5_post_we0", we_vec, 6'b000000);
    tick();
    chk("t5_post_we1", we_vec, 6'b000000);
    chk("t5_post_wb", wb_data, 0);
    chk("t5_post_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poc_wb_demux.md
# poc_wb_demux

Writeback demultiplexer for the C side of the datapath: the inverse of the ALU A-bus source mux. It accepts an 18-bit ALU result plus a 3-bit destination code over a valid/ready handshake, buffers it in a small in-order FIFO, and issues exactly one registered write-enable pulse with data to the selected register (IDR, MDR, Rcol, Rrow, AC, R1). It sits between the ALU output and the `din`/`write` inputs of the register blocks.

## Interface
- `DATA_W`, 18, datapath width
- `IDR_W`, 9, IDR input width; IDR receives `wb_data[IDR_W-1:0]`
- `DEPTH`, 2, FIFO entries; power of two, at least 2
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset; one clock, synchronous, active-high
- `in_valid` in 1: result offered
- `in_ready` out 1: FIFO can accept
- `in_dest` in 3: destination code
- `in_data` in DATA_W: ALU result
- `mdr_busy` in 1: memory holds MDR; MDR writes must stall
- `wb_data` out DATA_W: registered write data, shared by all targets
- `idr_din` out IDR_W: `wb_data` truncated to the low IDR_W bits
- `we_idr`, `we_mdr`, `we_rcol`, `we_rrow`, `we_ac`, `we_r1` out 1 each: one-cycle write pulses
- `err_dest` out 1: one-cycle pulse on an illegal destination

## Operation
- Destination codes: 0 NONE (discard), 1 IDR, 2 MDR, 3 RCOL, 4 RROW, 5 AC, 6 R1, 7 illegal.
- Push when `in_valid && in_ready`; `in_ready = (count != DEPTH)`, derived combinationally from registered count only and independent of `in_valid`.
- Head issue is strictly in order.
  - Head stalls only if its dest is MDR and `mdr_busy` is high.
  - Any other head pops in the cycle it is at the front.
- On pop:
  - dest 1–6: the matching `we_*` and `wb_data` are registered for exactly one cycle.
  - dest 0: pop with no pulse.
  - dest 7: pop, `err_dest` pulses, no `we_*`.
- At most one `we_*` is high in any cycle; all are 0 when no pop occurred.
- `wb_data` holds its last value when no write issues.
- IDR truncation drops the upper bits silently; no flag.
- Push and pop in the same cycle are both honoured; count is unchanged. When full, only a pop can occur.
- Reset:
  - count := 0; FIFO pointers := 0.
  - `wb_data`, `idr_din`, all `we_*`, `err_dest` := 0; `in_ready` reads 1 after reset.
  - Reset mid-operation drops buffered entries without issuing writes.

## Timing
- Push on edge k into an empty FIFO with no stall: `we_*`/`wb_data` are high between edges k+1 and k+2, and the target register captures on edge k+2.
- Throughput is one write per cycle when unstalled.
- A stalled MDR head blocks everything behind it. When `mdr_busy` drops before edge m, the write pulses in the cycle after edge m.
- `mdr_busy` is sampled only in the issue decision. It has no effect on an MDR pulse already registered.

## Configuration
- `POC_WB_STATS_EN`
  - Defined: adds outputs `stat_writes` [15:0] (incremented per `we_*` pulse) and `stat_drops` [15:0] (incremented per dest 0 or 7 pop). Both are saturating at 16'hFFFF and cleared by `rst`.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `poc_pkg`:
  - destination enum (`DEST_NONE` … `DEST_ILLEGAL`)
  - `POC_DATA_W = 18`, `POC_IDR_W = 9`
  - the same codes used by the ALU A-mux select, where they overlap.
- Sub-module `poc_wb_fifo`: synchronous FIFO with count, push/pop, `full`/`empty`, and reset as above.
- Top level holds the issue logic and the registered decode.

## Test plan
- Push (dest 3, data 65) into an empty FIFO → `we_rcol` = 1 for one cycle at k+1 with `wb_data` = 65; no other `we_*` high.
- Back-to-back pushes (1, 23), (2, 19), (4, 54) with `mdr_busy` = 0 → pulses `we_idr` (`idr_din` = 23), `we_mdr` (19), `we_rrow` (54) on consecutive cycles; `in_ready` never drops.
- `mdr_busy` = 1, push (2, 19) then (5, 7) → `in_ready` = 0 after the second push and no pulses. Drop `mdr_busy` → `we_mdr` (19), then `we_ac` (7) on the next cycle.
- Push (1, 0x3FFFF) → `idr_din` = 0x1FF.
  - Push (0, 5) → no pulse.
  - Push (7, 9) → `err_dest` pulses once; `stat_drops` = 2 under `POC_WB_STATS_EN`.
- Fill the FIFO, then assert `rst` for one cycle → no `we_*` afterwards, `in_ready` = 1, all outputs 0.
